matmul_job_sched: RTL and testbench

- Job scheduler and sequencer for the 6x6 matrix multiplier datapath.
- Accepts job descriptors (size plus A/B/C base addresses) from a host into a small FIFO.
- For each job it starts the multiplier, serves the A and B operand streams from a shared word memory, and writes the 32-bit products back to memory.
- It reports completion or error for every job, and sits between the host/memory subsystem and the multiplier.

---
 rtl/matmul_job_sched_if.sv | 30 +++
 rtl/matmul_job_sched.sv | 184 ++++++++++++++++++
 tb/tb_matmul_job_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_job_sched_if.sv
// Job descriptor handshake between host and the matmul job scheduler.
// A descriptor transfers on any clock edge where job_valid & job_ready.
interface matmul_job_sched_if #(
    parameter int ADDR_W = 10
);
    logic              job_valid;
    logic              job_ready;
    logic [3:0]        job_size;
    logic [ADDR_W-1:0] job_a_base;
    logic [ADDR_W-1:0] job_b_base;
    logic [ADDR_W-1:0] job_c_base;

    modport master (
        output job_valid,
        output job_size,
        output job_a_base,
        output job_b_base,
        output job_c_base,
        input  job_ready
    );

    modport slave (
        input  job_valid,
        input  job_size,
        input  job_a_base,
        input  job_b_base,
        input  job_c_base,
        output job_ready
    );
endinterface

// File: rtl/matmul_job_sched.sv
// Job scheduler for the 6x6 matrix multiplier: queues descriptors,
// starts each job, serves A/B operands and forwards results to memory.
module matmul_job_sched #(
    parameter int MAX_SIZE   = 6,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rstn,
    matmul_job_sched_if.slave   job,
    output logic                job_done,
    output logic                job_err,
    output logic                busy,
    output logic [ADDR_W-1:0]   mem_raddr,
    input  logic signed [15:0]  mem_rdata,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [31:0]         mem_wdata,
    output logic                mm_start,
    output logic [3:0]          mm_sizes,
    input  logic                mm_ren,
    input  logic                mm_raddr,
    output logic signed [15:0]  mm_rdata,
    input  logic                mm_wen,
    input  logic [31:0]         mm_wdata,
    input  logic                mm_finish
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [3:0]        size;
        logic [ADDR_W-1:0] a_base;
        logic [ADDR_W-1:0] b_base;
        logic [ADDR_W-1:0] c_base;
    } desc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    desc_t            fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W:0]   cnt_q;

    state_t           state_q;
    desc_t            cur_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic             sel_q;
    logic             start_q;
    logic             done_q;
    logic             err_q;

    desc_t             desc_in;
    logic              full;
    logic              empty;
    logic              accept;
    logic              size_ok;
    logic              push;
    logic              pop;
    logic              adm_err;
    logic [CNT_W-1:0]  rd_eff;
    logic [CNT_W-1:0]  rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_d;
    logic [CNT_W-1:0]  nn;
    logic [ADDR_W-1:0] rd_base;

    always_comb begin
        desc_in.size   = job.job_size;
        desc_in.a_base = job.job_a_base;
        desc_in.b_base = job.job_b_base;
        desc_in.c_base = job.job_c_base;
    end

    assign full    = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign accept  = job.job_valid & ~full;
    assign size_ok = (job.job_size != 4'd0) &&
                     (job.job_size <= 4'(MAX_SIZE));
    assign push    = accept & size_ok;
    assign adm_err = accept & ~size_ok;
    assign pop     = (state_q == S_IDLE) & ~empty;

    assign job.job_ready = ~full;
    assign busy          = (state_q != S_IDLE) | ~empty;

    // A change of operand select restarts the stream at its base at once.
    assign rd_eff   = (mm_raddr != sel_q) ? '0 : rd_cnt_q;
    assign rd_cnt_d = rd_eff + CNT_W'(mm_ren);
    assign rd_base  = mm_raddr ? cur_q.b_base : cur_q.a_base;
    assign mem_raddr = rd_base + ADDR_W'(rd_eff);
    assign mm_rdata  = mem_rdata;

    assign mem_wen   = mm_wen & (state_q == S_RUN);
    assign mem_waddr = cur_q.c_base + ADDR_W'(wr_cnt_q);
    assign mem_wdata = mm_wdata;
    assign wr_cnt_d  = wr_cnt_q + CNT_W'(mem_wen);
    assign nn        = CNT_W'(cur_q.size) * CNT_W'(cur_q.size);

    assign mm_start = start_q;
    assign mm_sizes = cur_q.size;
    assign job_done = done_q;
    assign job_err  = err_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= desc_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            sel_q    <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= adm_err;
            sel_q   <= mm_raddr;
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        cur_q   <= fifo_q[rptr_q];
                        start_q <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    rd_cnt_q <= '0;
                    wr_cnt_q <= '0;
                    state_q  <= S_RUN;
                end
                S_RUN: begin
                    rd_cnt_q <= rd_cnt_d;
                    wr_cnt_q <= wr_cnt_d;
                    if (mm_finish) begin
                        done_q  <= 1'b1;
                        err_q   <= adm_err | (wr_cnt_d != nn);
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_job_sched.sv
// Directed bench for matmul_job_sched with a behavioural multiplier stub
// and operand/result memories.
module tb_matmul_job_sched;

    logic               clk;
    logic               rstn;
    logic               job_done;
    logic               job_err;
    logic               busy;
    logic [9:0]         mem_raddr;
    logic signed [15:0] mem_rdata;
    logic               mem_wen;
    logic [9:0]         mem_waddr;
    logic [31:0]        mem_wdata;
    logic               mm_start;
    logic [3:0]         mm_sizes;
    logic               mm_ren;
    logic               mm_raddr;
    logic signed [15:0] mm_rdata;
    logic               mm_wen;
    logic [31:0]        mm_wdata;
    logic               mm_finish;

    matmul_job_sched_if #(.ADDR_W(10)) ifc ();

    matmul_job_sched #(
        .MAX_SIZE  (6),
        .ADDR_W    (10),
        .FIFO_DEPTH(2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .job      (ifc),
        .job_done (job_done),
        .job_err  (job_err),
        .busy     (busy),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .mem_wen  (mem_wen),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .mm_start (mm_start),
        .mm_sizes (mm_sizes),
        .mm_ren   (mm_ren),
        .mm_raddr (mm_raddr),
        .mm_rdata (mm_rdata),
        .mm_wen   (mm_wen),
        .mm_wdata (mm_wdata),
        .mm_finish(mm_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [15:0] amem [1024];
    logic [31:0]        cmem [1024] = '{default: 32'hDEAD_BEEF};

    assign mem_rdata = amem[mem_raddr];

    always @(posedge clk) begin
        if (mem_wen) cmem[mem_waddr] <= mem_wdata;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge.
    int         cyc = 0;
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    int         wr_tot = 0;
    int         busy_drops = 0;
    int         start_gap = 0;
    int         last_done_cyc = 0;
    bit         watch_busy = 0;
    logic [3:0] start_sz [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mm_start) begin
            start_cnt++;
            start_gap = cyc - last_done_cyc;
            start_sz.push_back(mm_sizes);
        end
        if (job_done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (job_err) err_cnt++;
        if (job_done && job_err) both_cnt++;
        if (mem_wen) wr_tot++;
        if (watch_busy && !busy) busy_drops++;
    end

    // Multiplier stub: reads A then B, multiplies, writes C row-major.
    int stub_hold = 0;
    int stub_nw   = 0;

    task automatic stub_idle();
        mm_ren    = 1'b0;
        mm_raddr  = 1'b0;
        mm_wen    = 1'b0;
        mm_wdata  = '0;
        mm_finish = 1'b0;
    endtask

    task automatic run_job();
        int n;
        int nw;
        int sa [64];
        int sb [64];
        int sc [64];
        n = int'(mm_sizes);
        for (int i = 0; i < n * n; i++) begin
            @(posedge clk); #1;
            mm_ren = 1'b1; mm_raddr = 1'b0;
            @(negedge clk);
            if (!rstn) begin stub_idle(); return; end
            sa[i] = int'(mm_rdata);
        end
        for (int i = 0; i < n * n; i++) begin
            @(posedge clk); #1;
            mm_ren = 1'b1; mm_raddr = 1'b1;
            @(negedge clk);
            if (!rstn) begin stub_idle(); return; end
            sb[i] = int'(mm_rdata);
        end
        @(posedge clk); #1;
        mm_ren = 1'b0;
        repeat (stub_hold) @(posedge clk);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                sc[i*n+j] = 0;
                for (int k = 0; k < n; k++)
                    sc[i*n+j] += sa[i*n+k] * sb[k*n+j];
            end
        end
        nw = (stub_nw != 0) ? stub_nw : n * n;
        for (int i = 0; i < nw; i++) begin
            @(posedge clk); #1;
            mm_wen = 1'b1; mm_wdata = 32'(sc[i]);
            @(negedge clk);
            if (!rstn) begin stub_idle(); return; end
        end
        @(posedge clk); #1;
        mm_wen = 1'b0; mm_finish = 1'b1;
        @(negedge clk);
        if (!rstn) begin stub_idle(); return; end
        @(posedge clk); #1;
        mm_finish = 1'b0;
    endtask

    initial begin
        stub_idle();
        forever begin
            @(negedge clk);
            if (rstn && mm_start) run_job();
        end
    end

    function automatic logic [31:0] gold(int n, int a, int b, int i, int j);
        int s = 0;
        for (int k = 0; k < n; k++)
            s += int'(amem[10'(a + i*n + k)]) * int'(amem[10'(b + k*n + j)]);
        return 32'(s);
    endfunction

    task automatic chk_c(input string tag, input int n, input int a,
                         input int b, input int c);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                chk(tag, cmem[10'(c + i*n + j)], gold(n, a, b, i, j));
    endtask

    task automatic push(input logic [3:0] sz, input logic [9:0] a,
                        input logic [9:0] b, input logic [9:0] c);
        int t = 0;
        ifc.job_valid  = 1'b1;
        ifc.job_size   = sz;
        ifc.job_a_base = a;
        ifc.job_b_base = b;
        ifc.job_c_base = c;
        while (1) begin
            @(negedge clk);
            if (ifc.job_ready) break;
            t++;
            if (t > 1000) begin
                chk("push_tmo", 32'(ifc.job_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        ifc.job_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt < target) chk("done_tmo", 32'(done_cnt), 32'(target));
    endtask

    int s0, d0, e0, w0, b0, q0;
    int ord [4] = '{2, 3, 1, 2};

    initial begin
        rstn = 1'b0;
        ifc.job_valid  = 1'b0;
        ifc.job_size   = '0;
        ifc.job_a_base = '0;
        ifc.job_b_base = '0;
        ifc.job_c_base = '0;
        for (int i = 0; i < 1024; i++) amem[i] = 16'(((i * 7) % 23) - 11);
        for (int i = 0; i < 4; i++) begin
            amem[i]      = 16'(i + 1);
            amem[16 + i] = 16'(i + 5);
        end
        repeat (3) @(posedge clk); #1;
        chk("rst_ready", 32'(ifc.job_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(job_done), 32'd0);
        chk("rst_err", 32'(job_err), 32'd0);
        chk("rst_start", 32'(mm_start), 32'd0);
        chk("rst_sizes", 32'(mm_sizes), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_raddr", 32'(mem_raddr), 32'd0);
        chk("rst_waddr", 32'(mem_waddr), 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // single 2x2 job
        s0 = start_cnt; d0 = done_cnt; e0 = err_cnt; w0 = wr_tot;
        push(4'd2, 10'h000, 10'h010, 10'h020);
        wait_done(d0 + 1);
        repeat (3) @(posedge clk); #1;
        chk("j1_starts", 32'(start_cnt - s0), 32'd1);
        chk("j1_writes", 32'(wr_tot - w0), 32'd4);
        chk("j1_errs", 32'(err_cnt - e0), 32'd0);
        chk("j1_c0", cmem[10'h020], 32'd19);
        chk("j1_c1", cmem[10'h021], 32'd22);
        chk("j1_c2", cmem[10'h022], 32'd43);
        chk("j1_c3", cmem[10'h023], 32'd50);
        chk("j1_c4_untouched", cmem[10'h024], 32'hDEAD_BEEF);

        // back-to-back 6x6 then 3x3
        d0 = done_cnt; w0 = wr_tot; busy_drops = 0;
        push(4'd6, 10'h100, 10'h140, 10'h200);
        watch_busy = 1;
        push(4'd3, 10'h180, 10'h1A0, 10'h300);
        wait_done(d0 + 2);
        watch_busy = 0;
        repeat (3) @(posedge clk); #1;
        chk("b2b_gap", 32'(start_gap), 32'd2);
        chk("b2b_writes", 32'(wr_tot - w0), 32'd45);
        chk("b2b_busy_drops", 32'(busy_drops), 32'd0);
        chk_c("b2b_c6", 6, 10'h100, 10'h140, 10'h200);
        chk_c("b2b_c3", 3, 10'h180, 10'h1A0, 10'h300);

        // invalid sizes are accepted and dropped
        s0 = start_cnt; e0 = err_cnt;
        push(4'd0, 10'h000, 10'h010, 10'h3C0);
        push(4'd7, 10'h000, 10'h010, 10'h3C0);
        repeat (4) @(posedge clk); #1;
        chk("inv_errs", 32'(err_cnt - e0), 32'd2);
        chk("inv_starts", 32'(start_cnt - s0), 32'd0);
        chk("inv_busy", 32'(busy), 32'd0);
        chk("inv_ready", 32'(ifc.job_ready), 32'd1);

        // FIFO full while the multiplier is held busy
        stub_hold = 30;
        d0 = done_cnt; q0 = start_sz.size();
        push(4'd2, 10'h000, 10'h010, 10'h040);
        push(4'd3, 10'h180, 10'h1A0, 10'h050);
        push(4'd1, 10'h100, 10'h140, 10'h060);
        chk("full_ready", 32'(ifc.job_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        b0 = done_cnt;
        push(4'd2, 10'h100, 10'h140, 10'h070);
        chk("full_acc_after_done", 32'(done_cnt - b0), 32'd1);
        wait_done(d0 + 4);
        repeat (3) @(posedge clk); #1;
        stub_hold = 0;
        for (int k = 0; k < 4; k++)
            chk("full_order", 32'(start_sz[q0 + k]), 32'(ord[k]));
        chk_c("full_c0", 2, 10'h000, 10'h010, 10'h040);
        chk_c("full_c1", 3, 10'h180, 10'h1A0, 10'h050);
        chk_c("full_c2", 1, 10'h100, 10'h140, 10'h060);
        chk_c("full_c3", 2, 10'h100, 10'h140, 10'h070);

        // result count mismatch
        stub_nw = 3;
        d0 = done_cnt; e0 = err_cnt; b0 = both_cnt;
        push(4'd2, 10'h000, 10'h010, 10'h080);
        wait_done(d0 + 1);
        repeat (3) @(posedge clk); #1;
        stub_nw = 0;
        chk("mis_done", 32'(done_cnt - d0), 32'd1);
        chk("mis_err", 32'(err_cnt - e0), 32'd1);
        chk("mis_same_cycle", 32'(both_cnt - b0), 32'd1);

        // reset in the middle of a 4x4 job
        s0 = start_cnt; d0 = done_cnt;
        push(4'd4, 10'h100, 10'h140, 10'h0C0);
        repeat (38) @(posedge clk); #1;
        chk("rr_started", 32'(start_cnt - s0), 32'd1);
        w0 = wr_tot;
        rstn = 1'b0;
        #1;
        chk("rr_wen", 32'(mem_wen), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_ready", 32'(ifc.job_ready), 32'd1);
        chk("rr_sizes", 32'(mm_sizes), 32'd0);
        chk("rr_start", 32'(mm_start), 32'd0);
        chk("rr_done", 32'(job_done), 32'd0);
        repeat (4) @(posedge clk); #1;
        rstn = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("rr_no_writes", 32'(wr_tot - w0), 32'd0);
        chk("rr_no_done", 32'(done_cnt - d0), 32'd0);
        d0 = done_cnt; e0 = err_cnt; w0 = wr_tot;
        push(4'd3, 10'h180, 10'h1A0, 10'h340);
        wait_done(d0 + 1);
        repeat (3) @(posedge clk); #1;
        chk("rr_new_writes", 32'(wr_tot - w0), 32'd9);
        chk("rr_new_err", 32'(err_cnt - e0), 32'd0);
        chk_c("rr_new_c", 3, 10'h180, 10'h1A0, 10'h340);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
